spi_slave_regs: RTL and testbench

//  SPI mode-0 slave with an 8-bit register bank; the far end of the SPI master's link (ss/sck/mosi in, miso out).

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync.sv | 35 +++
 rtl/spi_slave_regs.sv | 218 +++++++++++++++++++++
 tb/tb_spi_slave_regs.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI link definitions: frame IDs, frame length and slave FSM state encodings.
package spi_pkg;

  localparam logic [7:0] SLAVE_IDW  = 8'h64;   // write frame ID
  localparam logic [7:0] SLAVE_IDR  = 8'h65;   // read frame ID
  localparam logic [4:0] FRAME_BITS = 5'd24;   // {ID, ADDR, DATA}

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ID     = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4,
    ST_IGNORE = 3'd5
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser for an asynchronous pin, with one-clk rise/fall pulses
// derived from the synchronised level. RST_VAL sets the idle level of the chain.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  // Metastability chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
      prev_reg <= RST_VAL;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign dout = sync_reg;
  assign rise = sync_reg & ~prev_reg;
  assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave decoding 24-bit {ID, ADDR, DATA} frames into an 8-bit
// register bank. Writes commit at the 24th bit; reads shift the addressed
// register out on miso during the DATA byte. The bank is also readable locally.
module spi_slave_regs
  import spi_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter int         AW        = $clog2(DEPTH),
  parameter logic [7:0] SLAVE_IDW = spi_pkg::SLAVE_IDW,
  parameter logic [7:0] SLAVE_IDR = spi_pkg::SLAVE_IDR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ss,
  input  logic          sck,
  input  logic          mosi,
  output logic          miso,
  input  logic [AW-1:0] host_addr,
  output logic [7:0]    host_rdata,
  output logic          wr_pulse,
  output logic [7:0]    wr_addr,
  output logic [7:0]    wr_data,
  output logic          frame_err,
  output logic          busy
);

  localparam logic [8:0] DEPTH_9 = 9'(DEPTH);

  // Synchronised pins and edge events
  logic ss_s, ss_rise, ss_fall;
  logic sck_level_unused, sck_rise, sck_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .din(ss), .dout(ss_s), .rise(ss_rise), .fall(ss_fall)
  );
  spi_sync #(.RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .din(sck), .dout(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .din(mosi), .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // State and datapath registers
  spi_state_e  state_reg, state_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  rx_reg, rx_next;
  logic [7:0]  tx_reg;
  logic [7:0]  addr_reg;
  logic        rw_reg;
  logic        bad_addr_reg;
  logic        miso_reg;
  logic        wr_pulse_reg;
  logic [7:0]  wr_addr_reg;
  logic [7:0]  wr_data_reg;
  logic        frame_err_reg;
  logic        armed_reg;
  logic [1:0]  flush_cnt_reg;
  logic [7:0]  bank_reg [DEPTH];

  // Combinational decode results
  logic        sck_rise_v, sck_fall_v, frame_start;
  logic [4:0]  cnt_inc;
  logic [7:0]  rx_shifted;
  logic        addr_ok;
  logic        err_next, commit, latch_id, latch_addr;

  // SCK edges only count while selected; an ss rise in the same clk wins
  // because the synced ss is already high then.
  assign sck_rise_v  = sck_rise & ~ss_s;
  assign sck_fall_v  = sck_fall & ~ss_s;
  // After reset the ss chain starts at 1 even if the pin is low, so a frame
  // may only start once ss has genuinely been seen high.
  assign frame_start = ss_fall & armed_reg;
  assign cnt_inc     = bit_cnt_reg + 5'd1;
  assign rx_shifted  = {rx_reg[6:0], mosi_s};
  assign addr_ok     = ({1'b0, rx_shifted} < DEPTH_9);

  // Frame FSM: next state, bit counter/shift register and decode strobes.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    rx_next      = rx_reg;
    err_next     = 1'b0;
    commit       = 1'b0;
    latch_id     = 1'b0;
    latch_addr   = 1'b0;
    if (ss_rise) begin
      state_next = ST_IDLE;
      if (state_reg != ST_IDLE && state_reg != ST_DONE && state_reg != ST_IGNORE) begin
        err_next = (bit_cnt_reg != 5'd0);
      end
    end else if (frame_start) begin
      state_next   = ST_ID;
      bit_cnt_next = 5'd0;
    end else if (sck_rise_v && bit_cnt_reg != FRAME_BITS) begin
      bit_cnt_next = cnt_inc;
      rx_next      = rx_shifted;
      case (state_reg)
        ST_ID: begin
          if (cnt_inc == 5'd8) begin
            if (rx_shifted == SLAVE_IDW || rx_shifted == SLAVE_IDR) begin
              state_next = ST_ADDR;
              latch_id   = 1'b1;
            end else begin
              state_next = ST_IGNORE;
              err_next   = 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (cnt_inc == 5'd16) begin
            state_next = ST_DATA;
            latch_addr = 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_inc == FRAME_BITS) begin
            state_next = ST_DONE;
            if (bad_addr_reg) begin
              err_next = 1'b1;
            end else if (!rw_reg) begin
              commit = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state, counter and frame fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= 5'd0;
      rx_reg        <= 8'h00;
      rw_reg        <= 1'b0;
      addr_reg      <= 8'h00;
      bad_addr_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      rx_reg        <= rx_next;
      frame_err_reg <= err_next;
      if (latch_id) begin
        rw_reg <= (rx_shifted == SLAVE_IDR);
      end
      if (latch_addr) begin
        addr_reg     <= rx_shifted;
        bad_addr_reg <= ~addr_ok;
      end
    end
  end

  // Arm frame starts once the ss chain has flushed and shows ss high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_reg <= 2'd0;
      armed_reg     <= 1'b0;
    end else begin
      if (flush_cnt_reg != 2'd2) begin
        flush_cnt_reg <= flush_cnt_reg + 2'd1;
      end
      armed_reg <= armed_reg | ((flush_cnt_reg == 2'd2) & ss_s);
    end
  end

  // Read data path: load on the address byte, shift out on sck falls 16..23.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_reg   <= 8'h00;
      miso_reg <= 1'b0;
    end else if (ss_rise) begin
      miso_reg <= 1'b0;
    end else if (frame_start) begin
      tx_reg <= 8'h00;
    end else if (latch_addr) begin
      tx_reg <= (rw_reg && addr_ok) ? bank_reg[rx_shifted[AW-1:0]] : 8'h00;
    end else if (sck_fall_v) begin
      if (bit_cnt_reg >= 5'd16 && bit_cnt_reg < FRAME_BITS) begin
        miso_reg <= tx_reg[7];
        tx_reg   <= {tx_reg[6:0], 1'b0};
      end else if (bit_cnt_reg == FRAME_BITS) begin
        miso_reg <= 1'b0;
      end
    end
  end

  // Register bank and write-commit reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_reg[i] <= 8'h00;
      end
      wr_pulse_reg <= 1'b0;
      wr_addr_reg  <= 8'h00;
      wr_data_reg  <= 8'h00;
    end else begin
      wr_pulse_reg <= commit;
      if (commit) begin
        bank_reg[addr_reg[AW-1:0]] <= rx_shifted;
        wr_addr_reg                <= addr_reg;
        wr_data_reg                <= rx_shifted;
      end
    end
  end

  assign miso       = miso_reg;
  assign host_rdata = bank_reg[host_addr];
  assign wr_pulse   = wr_pulse_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = ~ss_s;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: drives SPI frames like a mode-0 master
// and checks bank contents, write reporting, error pulses and miso data.
module tb_spi_slave_regs;

  localparam int HALF = 8;   // sck half-period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       ss;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic [3:0] host_addr;
  logic [7:0] host_rdata;
  logic       wr_pulse;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       busy;

  int checks_total  = 0;
  int checks_passed = 0;
  int wr_cnt        = 0;
  int err_cnt       = 0;
  int miso_hi_cnt   = 0;

  always #5 clk = ~clk;

  spi_slave_regs dut (
    .clk(clk), .rst(rst), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso),
    .host_addr(host_addr), .host_rdata(host_rdata),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .busy(busy)
  );

  // Event counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_pulse)  wr_cnt++;
    if (frame_err) err_cnt++;
    if (miso)      miso_hi_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    host_addr = a;
    #1;
    d = host_rdata;
  endtask

  // One SPI transaction of nbits bits. If rst_bit is non-zero, reset is pulsed
  // right after that rise and the reset state is checked there.
  task automatic frame(input logic [7:0] id, input logic [7:0] addr, input logic [7:0] data,
                       input int nbits, input int rst_bit,
                       output logic [7:0] rdata, output int dwr, output int derr, output int dmiso);
    logic [23:0] word;
    logic [7:0]  rd;
    int wr0, err0, mh0;
    word  = {id, addr, data};
    rd    = 8'h00;
    wr0   = wr_cnt;
    err0  = err_cnt;
    mh0   = miso_hi_cnt;
    wait_clk(1);
    ss = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      wait_clk(1);
      mosi = word[23-i];
      wait_clk(HALF - 1);
      sck = 1'b1;
      if (i >= 16) rd[23-i] = miso;
      if (i + 1 == rst_bit) begin
        rst = 1'b1;
        host_addr = 4'd3;
        wait_clk(2);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bank3", {24'd0, host_rdata}, 32'h00);
        check("rst_wr_addr", {24'd0, wr_addr}, 32'h00);
        rst = 1'b0;
      end
      wait_clk(HALF);
      sck = 1'b0;
    end
    wait_clk(HALF);
    ss   = 1'b1;
    mosi = 1'b0;
    wait_clk(12);
    rdata = rd;
    dwr   = wr_cnt - wr0;
    derr  = err_cnt - err0;
    dmiso = miso_hi_cnt - mh0;
    $display("frame id=%02h addr=%02h data=%02h bits=%0d rdata=%02h wr=%0d err=%0d",
             id, addr, data, nbits, rd, dwr, derr);
  endtask

  logic [7:0] rd, v;
  int dwr, derr, dmiso;

  initial begin
    rst = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0; host_addr = 4'd0;
    wait_clk(4);
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_wr_pulse", {31'd0, wr_pulse}, 32'd0);
    check("reset_wr_addr", {24'd0, wr_addr}, 32'h00);
    check("reset_wr_data", {24'd0, wr_data}, 32'h00);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_bank0", {24'd0, host_rdata}, 32'h00);
    rst = 1'b0;
    wait_clk(10);

    // Plain write
    frame(8'h64, 8'h03, 8'hA5, 24, 0, rd, dwr, derr, dmiso);
    check("w03_pulses", dwr, 1);
    check("w03_err", derr, 0);
    check("w03_miso", dmiso, 0);
    check("w03_wr_addr", {24'd0, wr_addr}, 32'h03);
    check("w03_wr_data", {24'd0, wr_data}, 32'hA5);
    peek(4'd3, v);
    check("w03_bank", {24'd0, v}, 32'hA5);

    // Read back
    frame(8'h65, 8'h03, 8'h00, 24, 0, rd, dwr, derr, dmiso);
    check("r03_rdata", {24'd0, rd}, 32'hA5);
    check("r03_pulses", dwr, 0);
    check("r03_err", derr, 0);
    peek(4'd3, v);
    check("r03_bank", {24'd0, v}, 32'hA5);
    check("r03_miso_idle", {31'd0, miso}, 32'd0);

    // Bad ID
    frame(8'h66, 8'h03, 8'h5A, 24, 0, rd, dwr, derr, dmiso);
    check("badid_err", derr, 1);
    check("badid_pulses", dwr, 0);
    check("badid_miso", dmiso, 0);
    peek(4'd3, v);
    check("badid_bank", {24'd0, v}, 32'hA5);

    // Out-of-range address, write then read
    frame(8'h64, 8'h20, 8'h77, 24, 0, rd, dwr, derr, dmiso);
    check("w20_err", derr, 1);
    check("w20_pulses", dwr, 0);
    check("w20_wr_data", {24'd0, wr_data}, 32'hA5);
    frame(8'h65, 8'h20, 8'h00, 24, 0, rd, dwr, derr, dmiso);
    check("r20_rdata", {24'd0, rd}, 32'h00);
    check("r20_err", derr, 1);

    // Short frame aborted after 12 bits, then a full write
    frame(8'h64, 8'h05, 8'h3C, 12, 0, rd, dwr, derr, dmiso);
    check("short_err", derr, 1);
    check("short_pulses", dwr, 0);
    peek(4'd5, v);
    check("short_bank", {24'd0, v}, 32'h00);
    frame(8'h64, 8'h05, 8'h3C, 24, 0, rd, dwr, derr, dmiso);
    check("w05_pulses", dwr, 1);
    check("w05_err", derr, 0);
    check("w05_wr_addr", {24'd0, wr_addr}, 32'h05);
    peek(4'd5, v);
    check("w05_bank", {24'd0, v}, 32'h3C);
    peek(4'd3, v);
    check("w05_bank3", {24'd0, v}, 32'hA5);

    // Reset in the middle of a read at bit 20
    frame(8'h65, 8'h03, 8'h00, 24, 20, rd, dwr, derr, dmiso);
    check("rstmid_pulses", dwr, 0);
    peek(4'd5, v);
    check("rstmid_bank5", {24'd0, v}, 32'h00);
    frame(8'h64, 8'h07, 8'hC3, 24, 0, rd, dwr, derr, dmiso);
    check("w07_pulses", dwr, 1);
    check("w07_wr_data", {24'd0, wr_data}, 32'hC3);
    frame(8'h65, 8'h07, 8'h00, 24, 0, rd, dwr, derr, dmiso);
    check("r07_rdata", {24'd0, rd}, 32'hC3);
    check("r07_err", derr, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
